// File: rtl/ifu.sv
// Instruction fetch unit: holds the PC and fetches one word at a time from
// instruction memory using a req/gnt + rvalid interface. It keeps at most one
// fetch in flight. Returned words and their PCs are buffered in a small FIFO,
// and the FIFO head is presented to decode with a valid/ready handshake. A
// redirect flushes the buffer and any in-flight fetch, then restarts fetching
// at the new PC.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   imem_req/imem_addr   fetch request and word-aligned fetch address
//   imem_gnt             request accepted this cycle
//   imem_rvalid/rdata    fetched word, arriving at least one cycle after gnt
//   redirect/redirect_pc flush and restart fetch at redirect_pc (bits [1:0] ignored)
//   instr_valid/ready    handshake with decode for the buffer head
//   instr                head instruction bits [31:2]
//   instr_pc             PC of the head instruction
//   instr_illegal        head word is not a 32-bit encoding ([1:0] != 2'b11)
module ifu #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     DEPTH        = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [29:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_illegal
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_req_pc;
  logic             r_outstanding;
  logic             r_drop;
  logic             r_rst_q;
  logic [31:0]      r_word [DEPTH];
  logic [XLEN-1:0]  r_epc  [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [CNT_W-1:0] w_occupied;
  logic             w_room;
  logic             w_accept;
  logic             w_resp;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_unused_redirect_lsb;

  assign w_unused_redirect_lsb = redirect_pc[1:0];

  // The in-flight fetch reserves a buffer slot, so a response always has room.
  assign w_occupied = r_count + CNT_W'(r_outstanding);
  assign w_room     = w_occupied < CNT_W'(DEPTH);

  // Stay quiet during the reset cycle and the cycle after it. A new fetch may
  // overlap the returning response of the current one.
  assign imem_req  = !rst && !r_rst_q && !redirect && !r_drop && w_room &&
                     (!r_outstanding || imem_rvalid);
  assign imem_addr = r_pc;

  assign w_accept = imem_req & imem_gnt;
  assign w_resp   = imem_rvalid & r_outstanding;
  assign w_push   = w_resp & !r_drop & !redirect;

  assign instr_valid   = !rst && (r_count != '0);
  assign w_pop         = instr_valid & instr_ready & !redirect;
  assign instr         = r_word[r_head][31:2];
  assign instr_pc      = r_epc[r_head];
  assign instr_illegal = r_word[r_head][1:0] != 2'b11;

  // Control state: PC, in-flight tracking, drop flag and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= {RESET_VECTOR[XLEN-1:2], 2'b00};
      r_req_pc      <= '0;
      r_outstanding <= 1'b0;
      r_drop        <= 1'b0;
      r_rst_q       <= 1'b1;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
    end else begin
      r_rst_q       <= 1'b0;
      r_outstanding <= w_accept | (r_outstanding & ~imem_rvalid);
      if (w_accept) begin
        r_req_pc <= r_pc;
        r_pc     <= r_pc + XLEN'(4);
      end
      if (redirect) begin
        // A fetch still in flight must have its response discarded later.
        r_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
        r_drop  <= r_outstanding & ~imem_rvalid;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_resp && r_drop) r_drop <= 1'b0;
        if (w_push) r_tail <= r_tail + PTR_W'(1);
        if (w_pop)  r_head <= r_head + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  // Buffer storage: no reset needed, because entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_word[r_tail] <= imem_rdata;
      r_epc[r_tail]  <= r_req_pc;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    w_push |-> (r_count < CNT_W'(DEPTH)));

endmodule

// File: doc/ifu.md
Name: ifu

Overview:
- Instruction fetch unit. It sits directly upstream of the integer decode unit.
- Holds the PC and issues word fetches to instruction memory over a req/gnt + rvalid interface.
- Buffers returned words with their PCs in a small FIFO and presents them to decode as instr[31:2] with a valid/ready handshake.
- Execute redirects it on taken branches and jumps, which flushes the buffer and any in-flight fetch.

Parameters:
- XLEN, 32, address/PC width.
- RESET_VECTOR, 0, PC loaded on reset; must be 4-byte aligned.
- DEPTH, 4, instruction buffer entries; power of two, >= 2.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request.
- imem_addr  output  XLEN  fetch address, always 4-byte aligned.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid, earliest one cycle after gnt.
- imem_rdata  input  32  fetched instruction word.
- redirect  input  1  flush and restart fetch.
- redirect_pc  input  XLEN  new PC; bits [1:0] ignored and treated as 0.
- instr_valid  output  1  buffer head valid.
- instr_ready  input  1  decode accepts head.
- instr  output  30  head instruction bits [31:2].
- instr_pc  output  XLEN  PC of head instruction.
- instr_illegal  output  1  head word has [1:0] != 2'b11 (non-32-bit encoding).

Behaviour:
- State:
  - pc (next fetch address).
  - outstanding (1 bit; at most one fetch in flight).
  - req_pc (PC of the in-flight fetch).
  - drop (discard next response).
  - FIFO of DEPTH entries {word[31:0], pc}, with count, head and tail pointers.
- Reset:
  - pc = RESET_VECTOR; outstanding = drop = 0; count = 0; pointers = 0.
  - Outputs in the reset cycle and the cycle after: imem_req = 0, instr_valid = 0.
  - imem_addr = pc. instr, instr_pc and instr_illegal are don't-care while instr_valid = 0.
- Issue condition:
  - imem_req = !redirect & !drop & (count + outstanding < DEPTH) & (!outstanding | imem_rvalid).
  - No combinational path from instr_ready to imem_req.
  - imem_addr = pc.
- Accept (imem_req & imem_gnt): req_pc <= pc; pc <= pc + 4, wrapping modulo 2^XLEN; outstanding <= 1.
  - If imem_req is high without gnt, imem_addr and imem_req hold until gnt, unless redirect withdraws them.
- Response (imem_rvalid & outstanding):
  - drop = 0: push {imem_rdata, req_pc}.
  - drop = 1: discard the word and clear drop.
  - In both cases outstanding clears, unless a new accept happens in the same cycle.
- imem_rvalid with outstanding = 0 is ignored.
- Output:
  - instr_valid = (count != 0).
  - instr = head.word[31:2]; instr_pc = head.pc; instr_illegal = (head.word[1:0] != 2'b11).
  - Pop when instr_valid & instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- Latency: gnt in cycle N, rvalid in N+1, instr_valid in N+2 (no bypass).
- Throughput: with a 1-cycle memory and decode always ready, one instruction per cycle in steady state.
- Redirect, highest priority:
  - Cycle effects: FIFO flushed (count = 0, pointers reset); pc <= {redirect_pc[XLEN-1:2], 2'b00}; imem_req = 0; pop ignored.
  - If outstanding is set and rvalid does not arrive in the same cycle, drop <= 1.
  - A response arriving in the redirect cycle is discarded.
  - Fetch restarts the cycle after redirect, or after the dropped response returns.
- Full FIFO: the issue condition guarantees no push when full; a push while full is a design error (assertion).
- Empty FIFO: a pop request is ignored.
- Reset mid-operation: all state clears. A later rvalid for a pre-reset fetch is ignored because outstanding = 0.

Test Plan:
- Reset with RESET_VECTOR=0x100, 1-cycle memory, decode always ready:
  - Fetch addresses are 0x100, 0x104, 0x108, ... on consecutive cycles.
  - instr_pc follows two cycles later; instr matches rdata[31:2].
- Hold instr_ready=0 for 10 cycles:
  - count saturates at DEPTH=4 and imem_req deasserts.
  - On release, 4 entries drain in PC order, then fetching resumes with no gap or duplicate.
- Redirect to 0x203 while one fetch is outstanding (rvalid two cycles later):
  - The stale word is dropped and the FIFO is empty.
  - Next fetch address is 0x200; the first instr_pc after that is 0x200.
- Hold imem_gnt=0 for 3 cycles with imem_req high:
  - imem_addr stays stable; pc advances exactly once, on the gnt cycle.
- rdata=0x00000013 then 0x00000012:
  - instr_illegal is 0, then 1.
  - instr = 0x00000013>>2 and 0x00000012>>2 respectively.
- Assert rst with 3 buffered entries and one outstanding, then return a late rvalid:
  - instr_valid = 0; the late rvalid is ignored.
  - First post-reset fetch address is RESET_VECTOR.
